// File: rtl/npu_sram_stream_reader_pkg.sv
// Shared widths, sequencer states and FIFO entry type for the SRAM port-2 stream reader.
package npu_sram_pkg;

    localparam int unsigned DEF_ADDR_W     = 12;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_LEN_W      = 13;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // One buffered word plus the end-of-transfer marker that travels with it.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
    } fifo_entry_t;

endpackage

// File: rtl/npu_sram_stream_reader_if.sv
// Valid/ready word stream, with a last marker, from the reader to the MAC array.
interface npu_sram_stream_reader_if #(
    parameter int unsigned DATA_W = npu_sram_pkg::DEF_DATA_W
);

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/npu_sram_stream_reader_fifo.sv
// First-word-fall-through FIFO with a registered valid flag; head is read straight from storage.
module npu_stream_fifo
    import npu_sram_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_FIFO_DEPTH,
    parameter type         entry_t = fifo_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  entry_t                       i_din,
    input  logic                         i_pop,
    output entry_t                       o_head,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;

    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_pop       = i_pop & r_valid;
    assign w_count_nxt = r_count + CNT_W'(i_push) - CNT_W'(w_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/npu_sram_stream_reader.sv
// Read DMA on SRAM port 2: walks base/stride/length, absorbs the 1-cycle read latency
// and streams words to the MAC array through a credit-limited FIFO.
module npu_sram_stream_reader
    import npu_sram_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LEN_W      = DEF_LEN_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [LEN_W-1:0]           length,
    input  logic [ADDR_W-1:0]          stride,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          sram_address,
    output logic                       sram_chipselect,
    output logic                       sram_write,
    output logic [1:0]                 sram_byteenable,
    input  logic [DATA_W-1:0]          sram_readdata,
    npu_sram_stream_reader_if.master   m
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W = CNT_W + 1;

    rd_state_e         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_cs;
    logic              r_cs_last;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_busy;
    logic              r_done;

    fifo_entry_t       w_push_entry;
    fifo_entry_t       w_head;
    logic              w_fifo_valid;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_pop;
    logic              w_credit_ok;
    logic              w_can_issue;
    logic              w_last_hs;

    assign w_push_entry = '{data: DEF_DATA_W'(sram_readdata), last: r_inflight_last};

    npu_stream_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_din   (w_push_entry),
        .i_pop   (m.m_ready),
        .o_head  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign w_pop     = w_fifo_valid & m.m_ready;
    assign w_last_hs = w_pop & w_head.last;

    // Occupancy next cycle plus the read issued now must leave room for one more read.
    assign w_count_nxt = w_fifo_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
    assign w_credit_ok = (CRD_W'(w_count_nxt) + CRD_W'(r_cs)) < CRD_W'(FIFO_DEPTH);
    assign w_can_issue = (r_remaining != '0) && w_credit_ok;

    // r_cs marks the cycle a read is on the bus; r_remaining excludes that word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_stride        <= '0;
            r_remaining     <= '0;
            r_cs            <= 1'b0;
            r_cs_last       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= r_cs;
            r_inflight_last <= r_cs & r_cs_last;

            case (r_state)
                IDLE: begin
                    r_cs <= 1'b0;
                    if (start) begin
                        if (length != '0) begin
                            r_state     <= ISSUE;
                            r_busy      <= 1'b1;
                            r_cs        <= 1'b1;
                            r_cs_last   <= (length == LEN_W'(1));
                            r_addr      <= base_addr;
                            r_stride    <= stride;
                            r_remaining <= length - LEN_W'(1);
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    r_cs <= w_can_issue;
                    if (r_cs) begin
                        r_addr <= r_addr + r_stride;
                    end
                    if (w_can_issue) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_cs_last   <= (r_remaining == LEN_W'(1));
                    end
                    if (r_cs && r_cs_last) begin
                        r_state <= DRAIN;
                    end
                end

                DRAIN: begin
                    r_cs <= 1'b0;
                    if (w_last_hs) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cs    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign sram_address    = r_addr;
    assign sram_chipselect = r_cs;
    assign sram_write      = 1'b0;
    assign sram_byteenable = 2'b11;

    assign m.m_data  = DATA_W'(w_head.data);
    assign m.m_valid = w_fifo_valid;
    assign m.m_last  = w_head.last & w_fifo_valid;

endmodule

// File: tb/tb_npu_sram_stream_reader.sv
// Bench for npu_sram_stream_reader: SRAM model with 1-cycle read latency, stream monitor,
// and a reference built from base + i*stride addressing.
module tb_npu_sram_stream_reader;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 16;
    localparam int unsigned LW    = 13;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic [AW-1:0] stride;
    logic          busy;
    logic          done;
    logic [AW-1:0] sram_address;
    logic          sram_chipselect;
    logic          sram_write;
    logic [1:0]    sram_byteenable;
    logic [DW-1:0] sram_readdata = '0;

    npu_sram_stream_reader_if #(.DATA_W(DW)) m_if ();

    npu_sram_stream_reader #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .LEN_W      (LW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .base_addr       (base_addr),
        .length          (length),
        .stride          (stride),
        .busy            (busy),
        .done            (done),
        .sram_address    (sram_address),
        .sram_chipselect (sram_chipselect),
        .sram_write      (sram_write),
        .sram_byteenable (sram_byteenable),
        .sram_readdata   (sram_readdata),
        .m               (m_if)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [4096];
    always @(posedge clk) begin
        if (sram_chipselect && !sram_write) sram_readdata <= mem[sram_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    int issue_addr_q[$], issue_cyc_q[$];
    int out_d_q[$], out_l_q[$], out_cyc_q[$];
    int exp_addr_q[$], exp_d_q[$], exp_l_q[$];
    int exp_done = 0;
    int done_cnt = 0, valid_cnt = 0, stall_viol = 0, bus_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    // Observe bus and stream mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (sram_write !== 1'b0 || sram_byteenable !== 2'b11) bus_viol++;
            if (sram_chipselect) begin
                issue_addr_q.push_back(int'(sram_address));
                issue_cyc_q.push_back(cyc);
            end
            if (m_if.m_valid) valid_cnt++;
            if (prev_stall && !(m_if.m_valid === 1'b1 && m_if.m_data === prev_data &&
                                m_if.m_last === prev_last)) stall_viol++;
            if (m_if.m_valid && m_if.m_ready) begin
                out_d_q.push_back(int'(m_if.m_data));
                out_l_q.push_back(int'(m_if.m_last));
                out_cyc_q.push_back(cyc);
            end
            if (done) done_cnt++;
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_data  = m_if.m_data;
            prev_last  = m_if.m_last;
        end
    end

    int rdy_mode = 0;
    int rdy_lo   = -1;
    int rdy_hi   = -1;
    initial begin
        m_if.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) m_if.m_ready = ($urandom_range(0, 2) != 0);
            else               m_if.m_ready = !(cyc >= rdy_lo && cyc <= rdy_hi);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        issue_addr_q.delete(); issue_cyc_q.delete();
        out_d_q.delete(); out_l_q.delete(); out_cyc_q.delete();
        exp_addr_q.delete(); exp_d_q.delete(); exp_l_q.delete();
        exp_done = 0; done_cnt = 0; valid_cnt = 0; stall_viol = 0; bus_viol = 0;
    endtask

    // Pulses start in the current cycle and records what the transfer must produce.
    task automatic start_xfer(input int b, input int l, input int s, output int t);
        int a;
        t         = cyc;
        base_addr = AW'(b);
        length    = LW'(l);
        stride    = AW'(s);
        start     = 1'b1;
        for (int i = 0; i < l; i++) begin
            a = (b + i * s) % 4096;
            exp_addr_q.push_back(a);
            exp_d_q.push_back(int'(mem[a]));
            exp_l_q.push_back(int'(i == l - 1));
        end
        exp_done++;
        tick();
        start     = 1'b0;
        base_addr = AW'($urandom);
        length    = LW'($urandom_range(1, 4096));
        stride    = AW'($urandom);
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        int n = 0;
        dcyc = -1;
        while (done !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (done === 1'b1) dcyc = cyc;
        chk({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic check_xfer(input string tag);
        chk({tag, "_nwords"}, out_d_q.size(), exp_d_q.size());
        for (int i = 0; i < exp_d_q.size() && i < out_d_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), out_d_q[i], exp_d_q[i]);
            chk($sformatf("%s_last%0d", tag, i), out_l_q[i], exp_l_q[i]);
        end
        chk({tag, "_nissue"}, issue_addr_q.size(), exp_addr_q.size());
        for (int i = 0; i < exp_addr_q.size() && i < issue_addr_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), issue_addr_q[i], exp_addr_q[i]);
        end
        chk({tag, "_ndone"}, done_cnt, exp_done);
        chk({tag, "_stall_stable"}, stall_viol, 0);
        chk({tag, "_bus_const"}, bus_viol, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_cs"}, sram_chipselect, 1'b0);
        chk({tag, "_addr"}, sram_address, 0);
        chk({tag, "_write"}, sram_write, 1'b0);
        chk({tag, "_be"}, sram_byteenable, 2'b11);
        chk({tag, "_valid"}, m_if.m_valid, 1'b0);
        chk({tag, "_last"}, m_if.m_last, 1'b0);
        chk({tag, "_data"}, m_if.m_data, 0);
    endtask

    initial begin
        int t, t2, d, n;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        stride    = '0;
        for (int i = 0; i < 4096; i++) mem[i] = DW'(i + 'h100);
        repeat (3) tick();
        chk_reset_outputs("rst");
        reset = 1'b0;
        tick();
        clear_logs();

        // Basic transfer and latency.
        start_xfer('h010, 4, 1, t);
        chk("t1_cs", sram_chipselect, 1'b1);
        chk("t1_addr", sram_address, 'h010);
        chk("t1_busy", busy, 1'b1);
        wait_done("t1", d);
        chk("t1_done_cyc", d, t + 7);
        chk("t1_busy_off", busy, 1'b0);
        tick();
        chk("t1_first_cyc", (out_cyc_q.size() > 0) ? out_cyc_q[0] : -1, t + 3);
        chk("t1_last_cyc", (out_cyc_q.size() == 4) ? out_cyc_q[3] : -1, t + 6);
        chk("t1_word0", (out_d_q.size() > 0) ? out_d_q[0] : -1, 'h110);
        check_xfer("t1");

        // Address wrap.
        clear_logs();
        start_xfer('hFFE, 4, 1, t);
        wait_done("wrap", d);
        tick();
        check_xfer("wrap");

        // Positive and negative strides.
        clear_logs();
        start_xfer(0, 3, 3, t);
        wait_done("str3", d);
        tick();
        check_xfer("str3");
        clear_logs();
        start_xfer(5, 3, 'hFFF, t);
        wait_done("strm1", d);
        tick();
        check_xfer("strm1");

        // Backpressure window T+2..T+12.
        clear_logs();
        rdy_lo = cyc + 2;
        rdy_hi = cyc + 12;
        start_xfer('h040, 16, 1, t);
        wait_done("bp", d);
        tick();
        n = 0;
        foreach (issue_cyc_q[i]) if (issue_cyc_q[i] >= t + 1 && issue_cyc_q[i] <= t + 12) n++;
        chk("bp_stall_issues", (n <= int'(DEPTH) && n > 0), 1'b1);
        check_xfer("bp");
        rdy_lo = -1;
        rdy_hi = -1;

        // Zero-length command.
        clear_logs();
        start_xfer('h055, 0, 1, t);
        chk("len0_done", done, 1'b1);
        chk("len0_busy", busy, 1'b0);
        repeat (6) tick();
        chk("len0_nissue", issue_addr_q.size(), 0);
        chk("len0_valid", valid_cnt, 0);
        chk("len0_ndone", done_cnt, 1);

        // Start while busy is ignored.
        clear_logs();
        start_xfer('h020, 6, 2, t);
        base_addr = AW'('h300);
        length    = LW'(2);
        stride    = AW'(5);
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ign", d);
        tick();
        check_xfer("ign");

        // New start accepted in the done cycle.
        clear_logs();
        start_xfer('h080, 3, 1, t);
        wait_done("b2b_a", d);
        start_xfer('h090, 2, 7, t2);
        chk("b2b_cs", sram_chipselect, 1'b1);
        chk("b2b_addr", sram_address, 'h090);
        wait_done("b2b_b", d);
        tick();
        check_xfer("b2b");

        // Reset mid-transfer after five words.
        clear_logs();
        start_xfer('h200, 10, 1, t);
        n = 0;
        while (out_d_q.size() < 5 && n < 100) begin
            tick();
            n++;
        end
        chk("mrst_5words", out_d_q.size() >= 5, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outputs("mrst");
        clear_logs();
        repeat (10) tick();
        chk("mrst_ndone", done_cnt, 0);
        chk("mrst_nissue", issue_addr_q.size(), 0);
        chk("mrst_valid", valid_cnt, 0);
        start_xfer('h300, 5, 1, t);
        wait_done("post_rst", d);
        tick();
        check_xfer("post_rst");

        // Randomised transfers over random memory contents.
        for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
        for (int k = 0; k < 10; k++) begin
            clear_logs();
            rdy_mode = (k % 3 == 0) ? 0 : 1;
            start_xfer($urandom_range(0, 4095), $urandom_range(1, 40), $urandom_range(0, 4095), t);
            wait_done($sformatf("rnd%0d", k), d);
            tick();
            check_xfer($sformatf("rnd%0d", k));
        end
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
